// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported data memory between the CPU memory
// stage (port C) and the DMA engine (port D). One request is latched at a
// time. The CPU has fixed priority, but a starvation counter forces a DMA
// grant after STARVE_MAX consecutive CPU grants while DMA is waiting. A
// watchdog aborts a transfer whose memory never acknowledges.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_* / dma_*            request, we, addr, wdata in; ack pulse, rdata out
//   mem_en/we/addr/wdata     registered copy of the granted request
//   mem_rdata, mem_ack       memory response
//   owner                    last granted port (0 = CPU, 1 = DMA)
//   busy                     high in XFER and DONE
//   timeout_err              sticky watchdog abort flag
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  // Watchdog counts 0..TIMEOUT-1.
  localparam int WD_W = $clog2(TIMEOUT);

  logic [1:0]        r_state;
  logic [SC_W-1:0]   r_starve;
  logic [WD_W-1:0]   r_wd;
  logic              r_cpu_ack;
  logic              r_dma_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_owner;
  logic              r_busy;
  logic              r_timeout_err;

  logic              w_any_req;
  logic              w_grant_dma;
  logic              w_starved;
  logic              w_wd_expired;
  logic              w_xfer_end;
  logic [DATA_W-1:0] w_result;

  always_comb begin
    w_any_req    = cpu_req | dma_req;
    w_starved    = (r_starve == SC_W'(STARVE_MAX));
    // DMA wins when alone, or when the CPU has used up its starvation budget.
    w_grant_dma  = dma_req & (~cpu_req | w_starved);
    w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));
    w_xfer_end   = mem_ack | w_wd_expired;
    // A real acknowledge beats a simultaneous watchdog expiry.
    w_result     = mem_ack ? mem_rdata : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_starve      <= '0;
      r_wd          <= '0;
      r_cpu_ack     <= 1'b0;
      r_dma_ack     <= 1'b0;
      r_cpu_rdata   <= '0;
      r_dma_rdata   <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_owner       <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_grant_dma;
            r_mem_we    <= w_grant_dma ? dma_we    : cpu_we;
            r_mem_addr  <= w_grant_dma ? dma_addr  : cpu_addr;
            r_mem_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_wd        <= '0;
            r_state     <= S_XFER;
          end
          // Reaching the else-branch means dma_req=1 and the CPU was granted.
          if (w_grant_dma || !dma_req) begin
            r_starve <= '0;
          end else if (!w_starved) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        S_XFER: begin
          if (w_xfer_end) begin
            if (r_owner) begin
              r_dma_rdata <= w_result;
              r_dma_ack   <= 1'b1;
            end else begin
              r_cpu_rdata <= w_result;
              r_cpu_ack   <= 1'b1;
            end
            if (!mem_ack) begin
              r_timeout_err <= 1'b1;
            end
            r_mem_en <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack     = r_cpu_ack;
  assign dma_ack     = r_dma_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign dma_rdata   = r_dma_rdata;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign owner       = r_owner;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with
// STARVE_MAX = 4 and TIMEOUT = 8. A small memory responder raises mem_ack in
// the lat-th cycle of mem_en (lat = 0 means never); a negedge monitor logs
// grants, acks and mem_en activity for the checks.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          owner, busy, timeout_err;

  mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(4),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .owner      (owner),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder.
  int            lat  = 1;
  logic [DW-1:0] rval = '0;
  int            rcnt = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_en) rcnt++;
      else        rcnt = 0;
      mem_ack   = mem_en && (lat != 0) && (rcnt == lat);
      mem_rdata = mem_ack ? rval : ~rval;
    end
  end

  // Monitor.
  int   en_cycles = 0;
  int   en_rises  = 0;
  int   n_acks    = 0;
  int   both_acks = 0;
  logic en_prev   = 1'b0;
  logic grant_own [0:255];
  logic ack_dma   [0:255];
  always @(negedge clk) begin
    if (mem_en) en_cycles++;
    if (mem_en && !en_prev) begin
      grant_own[en_rises[7:0]] = owner;
      en_rises++;
    end
    en_prev = mem_en;
    if (cpu_ack || dma_ack) begin
      ack_dma[n_acks[7:0]] = dma_ack;
      n_acks++;
    end
    if (cpu_ack && dma_ack) both_acks++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input string tag, input int budget, output logic c, output logic d);
    c = 1'b0;
    d = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        c = cpu_ack;
        d = dma_ack;
        return;
      end
    end
    chk({tag, "_ack_wait"}, 64'd0, 64'd1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_mem_en"},  64'(mem_en), 64'd0);
    chk({tag, "_mem_we"},  64'(mem_we), 64'd0);
    chk({tag, "_acks"},    64'({cpu_ack, dma_ack}), 64'd0);
    chk({tag, "_owner"},   64'(owner), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_to_err"},  64'(timeout_err), 64'd0);
    chk({tag, "_addr"},    64'(mem_addr), 64'd0);
    chk({tag, "_wdata"},   64'(mem_wdata), 64'd0);
    chk({tag, "_c_rdata"}, 64'(cpu_rdata), 64'd0);
    chk({tag, "_d_rdata"}, 64'(dma_rdata), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic c, d;
    int   base_g, base_a, base_e;
    logic [9:0] got_g, got_a;

    // Reset state.
    repeat (3) tick();
    reset_chk("reset");
    rst = 1'b0;
    tick();

    // Single CPU read, 1-cycle memory latency.
    lat = 1; rval = 32'h1234_5678;
    base_e = en_cycles;
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
    tick();
    chk("rd_en",    64'(mem_en), 64'd1);
    chk("rd_we",    64'(mem_we), 64'd0);
    chk("rd_addr",  64'(mem_addr), 64'h40);
    chk("rd_busy",  64'(busy), 64'd1);
    tick();
    chk("rd_ack",   64'({cpu_ack, dma_ack}), 64'b10);
    chk("rd_rdata", 64'(cpu_rdata), 64'h1234_5678);
    chk("rd_en_off", 64'(mem_en), 64'd0);
    cpu_req = 1'b0;
    tick();
    chk("rd_ack_pulse", 64'(cpu_ack), 64'd0);
    chk("rd_idle_busy", 64'(busy), 64'd0);
    chk("rd_en_cycles", 64'(en_cycles - base_e), 64'd1);

    // Both ports held: C,C,C,C,D,C,C,C,C,D.
    base_g = en_rises; base_a = n_acks;
    cpu_addr = 32'h10; dma_addr = 32'h20; dma_we = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int k = 0; k < 10; k++) wait_ack("arb", 10, c, d);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      got_g[i] = grant_own[base_g + i];
      got_a[i] = ack_dma[base_a + i];
    end
    chk("arb_grant_order", 64'(got_g), 64'h210);
    chk("arb_ack_order",   64'(got_a), 64'h210);
    chk("arb_count",       64'(n_acks - base_a), 64'd10);

    // DMA write arrives mid CPU transfer, 3-cycle latency.
    lat = 3; rval = 32'hA5A5_A5A5;
    cpu_we = 1'b0; cpu_addr = 32'h80; cpu_wdata = 32'h1111_2222; cpu_req = 1'b1;
    tick();
    chk("mid_c_addr1", 64'(mem_addr), 64'h80);
    tick();
    dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hCAFE_F00D; dma_req = 1'b1;
    chk("mid_c_addr2", 64'(mem_addr), 64'h80);
    tick();
    chk("mid_c_fields", 64'({owner, mem_we, mem_addr[15:0], mem_wdata}), {31'd0, 1'b0, 1'b0, 16'h0080, 32'h1111_2222});
    chk("mid_c_en",     64'(mem_en), 64'd1);
    tick();
    chk("mid_c_ack",    64'({cpu_ack, dma_ack}), 64'b10);
    chk("mid_c_rdata",  64'(cpu_rdata), 64'hA5A5_A5A5);
    cpu_req = 1'b0;
    rval = 32'h5EED_0003;
    tick();
    chk("mid_idle_en",  64'(mem_en), 64'd0);
    tick();
    chk("mid_d_en",     64'(mem_en), 64'd1);
    chk("mid_d_fields", 64'({owner, mem_we, mem_addr[15:0], mem_wdata}), {31'd0, 1'b1, 1'b1, 16'h0100, 32'hCAFE_F00D});
    wait_ack("mid_d", 10, c, d);
    chk("mid_d_ack",    64'({c, d}), 64'b01);
    chk("mid_d_rdata",  64'(dma_rdata), 64'h5EED_0003);
    chk("mid_c_kept",   64'(cpu_rdata), 64'hA5A5_A5A5);
    dma_req = 1'b0; dma_we = 1'b0;
    tick();

    // Watchdog: memory never acknowledges.
    lat = 0;
    base_e = en_cycles;
    cpu_we = 1'b0; cpu_addr = 32'h200; cpu_req = 1'b1;
    wait_ack("to", 20, c, d);
    chk("to_ack",       64'({c, d}), 64'b10);
    chk("to_rdata",     64'(cpu_rdata), 64'hFFFF_FFFF);
    chk("to_err",       64'(timeout_err), 64'd1);
    chk("to_en_cycles", 64'(en_cycles - base_e), 64'd8);
    cpu_req = 1'b0;
    tick(); tick();
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    lat = 2; rval = 32'h0BAD_BEEF;
    dma_we = 1'b0; dma_addr = 32'h300; dma_req = 1'b1;
    wait_ack("to_next", 10, c, d);
    chk("to_next_ack",   64'({c, d}), 64'b01);
    chk("to_next_rdata", 64'(dma_rdata), 64'h0BAD_BEEF);
    chk("to_next_err",   64'(timeout_err), 64'd1);
    chk("to_next_ckeep", 64'(cpu_rdata), 64'hFFFF_FFFF);
    dma_req = 1'b0;
    tick();

    // Reset during a DMA read.
    lat = 0;
    dma_we = 1'b0; dma_addr = 32'h400; dma_req = 1'b1;
    tick();
    chk("rx_en",    64'({mem_en, owner}), 64'b11);
    tick(); tick();
    rst = 1'b1; dma_req = 1'b0;
    base_a = n_acks;
    tick();
    reset_chk("rx");
    rst = 1'b0;
    tick(); tick();
    chk("rx_no_ack", 64'(n_acks - base_a), 64'd0);
    lat = 1; rval = 32'h0000_0077;
    cpu_we = 1'b0; cpu_addr = 32'h44; cpu_req = 1'b1;
    wait_ack("rx_cpu", 10, c, d);
    chk("rx_cpu_ack",   64'({c, d}), 64'b10);
    chk("rx_cpu_rdata", 64'(cpu_rdata), 64'h77);
    cpu_req = 1'b0;
    tick();

    // Back-to-back CPU with req held across ack.
    lat = 1; rval = 32'h0000_0066;
    base_g = en_rises; base_a = n_acks;
    cpu_addr = 32'h48; cpu_req = 1'b1;
    wait_ack("b2b", 10, c, d);
    chk("b2b_ack1",  64'({c, d}), 64'b10);
    tick();
    chk("b2b_idle",  64'(mem_en), 64'd0);
    tick();
    chk("b2b_en2",   64'(mem_en), 64'd1);
    tick();
    chk("b2b_ack2",  64'(cpu_ack), 64'd1);
    cpu_req = 1'b0;
    repeat (3) tick();
    chk("b2b_issues", 64'(en_rises - base_g), 64'd2);
    chk("b2b_acks",   64'(n_acks - base_a), 64'd2);

    chk("no_dual_ack", 64'(both_acks), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
